serial_cfg_lut_bank: RTL and testbench
======================================

SERIAL_CFG_LUT_BANK -- requirements
Module: serial_cfg_lut_bank

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 4, LUT select width per channel.
REQ-002 SHALL have parameter OUT_WIDTH, default 4, LUT entry width.
REQ-003 SHALL have parameter N_LUTS, default 2, independent LUT channels (>=1).
REQ-004 SHALL derive TABLE_BITS = 2**IN_WIDTH * OUT_WIDTH and IDX_W = max(1, clog2(N_LUTS)).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cs_n  input  1  frame enable, active-low, sampled on clk.
REQ-008 SHALL have port d  input  1  serial data in, sampled on clk while cs_n low.
REQ-009 SHALL have port sel  input  N_LUTS*IN_WIDTH  channel k select = sel[k*IN_WIDTH +: IN_WIDTH].
REQ-010 SHALL have port out  output  N_LUTS*OUT_WIDTH  channel k registered LUT result.
REQ-011 SHALL have port q  output  1  serial readback data.
REQ-012 SHALL have port busy  output  1  high when FSM not in IDLE.
REQ-013 SHALL have port commit  output  1  one-cycle pulse on table update.
REQ-014 SHALL have port err  output  1  sticky frame error flag.

Function
REQ-015 SHALL store one active table of TABLE_BITS per channel; entry i = table[(i+1)*OUT_WIDTH-1 -: OUT_WIDTH].
REQ-016 SHALL register out: out[k] at edge n+1 = entry sel_k(n) of active table k at edge n; latency 1 cycle.
REQ-017 SHALL use FSM states IDLE, HEADER, WRITE, READ, HOLD.
REQ-018 IDLE -> HEADER on first edge with cs_n=0; that bit is header bit 0 (shifted in); err cleared on this edge.
REQ-019 Header = 1+IDX_W bits MSB-first: bit 0 RW (1=write, 0=read), then channel index MSB-first.
REQ-020 On edge sampling last header bit: RW=1 -> WRITE; RW=0 -> READ, load readback shifter with active table[idx].
REQ-021 WRITE: each cs_n=0 edge shifts d into shadow LSB (first data bit ends at MSB) and increments bit counter.
REQ-022 WRITE: cs_n=0 edge after TABLE_BITS data bits -> HOLD, err=1 (overrun), shadow discarded.
REQ-023 Frame end = edge sampling cs_n=1 while not IDLE; FSM -> IDLE on that edge.
REQ-024 Frame end in WRITE with count==TABLE_BITS and idx<N_LUTS: active[idx] <= shadow, commit=1 for exactly that next cycle.
REQ-025 Frame end in WRITE with count!=TABLE_BITS, or in HEADER: no table change, err=1.
REQ-026 idx>=N_LUTS: write never commits, read returns zeros; err=1 at frame end.
REQ-027 READ: q = shifter MSB combinationally; each cs_n=0 edge shifts left, zero-fill; beyond TABLE_BITS q=0, no error.
REQ-028 q SHALL be 0 in every state except READ.
REQ-029 Commit SHALL take effect on out one cycle after the commit edge (new table used for next registered lookup).
REQ-030 Tables of non-addressed channels SHALL never change; out of all channels SHALL keep updating during frames.
REQ-031 HOLD ignores d until frame end; err remains set until next frame start or reset.

Reset
REQ-032 rst_n=0 SHALL immediately clear all active tables, shadow, counters, out, commit, err, q and set FSM IDLE.
REQ-033 Reset mid-frame SHALL abort without commit; after release cs_n low starts a new frame only via IDLE->HEADER.

Verification
REQ-034 Reset, sel=all values -> out=0, q=0, busy=0, err=0, commit=0.
REQ-035 Write ch1: header 1,1 then 64 bits encoding entry i = 15-i, cs_n high -> commit pulse 1 cycle, sel ch1=3 -> out ch1=12 next cycle; ch0 still 0.
REQ-036 Read ch1 after REQ-035: header 0,1 -> q emits 64 bits equal to written stream, MSB first; err=0.
REQ-037 Write ch0 with 63 bits then cs_n high -> no commit, err=1, ch0 table unchanged; next frame start clears err.
REQ-038 Write ch0 with 65 bits -> HOLD, err=1, no commit; N_LUTS=3 write idx=3 -> err=1, no table change.
REQ-039 Assert rst_n=0 at data bit 30 of a write -> tables 0, no commit; full valid frame after release commits normally.

Source files
------------

// File: rtl/serial_cfg_lut_bank.sv
// Bank of N_LUTS independent registered lookup tables. Each table is loaded or read back
// over a serial frame (cs_n/d/q); a completed write frame commits atomically.
module serial_cfg_lut_bank #(
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned OUT_WIDTH = 4,
  parameter int unsigned N_LUTS    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cs_n,
  input  logic                          d,
  input  logic [N_LUTS*IN_WIDTH-1:0]    sel,
  output logic [N_LUTS*OUT_WIDTH-1:0]   out,
  output logic                          q,
  output logic                          busy,
  output logic                          commit,
  output logic                          err
);

  localparam int unsigned N_ENTRIES  = 2 ** IN_WIDTH;
  localparam int unsigned TABLE_BITS = N_ENTRIES * OUT_WIDTH;
  localparam int unsigned IDX_W      = (N_LUTS > 1) ? $clog2(N_LUTS) : 1;
  localparam int unsigned IDXE_W     = IDX_W + 1;
  localparam int unsigned HDR_BITS   = 1 + IDX_W;
  localparam int unsigned CNT_W      = $clog2(TABLE_BITS + 1);
  localparam int unsigned HCNT_W     = $clog2(HDR_BITS + 1);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_WRITE, S_READ, S_HOLD} state_t;

  state_t                  state, state_next;
  logic [HDR_BITS-1:0]     hdr;
  logic [HCNT_W-1:0]       hcnt;
  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        cnt;
  logic [TABLE_BITS-1:0]   shadow;
  logic [TABLE_BITS-1:0]   rd;
  logic [TABLE_BITS-1:0]   active [N_LUTS];

  logic [HDR_BITS-1:0]     hdr_next_c;
  logic [IDX_W-1:0]        idx_next_c;
  logic                    idx_ok_c;
  logic                    cnt_full_c;
  logic                    hdr_en_c, idx_load_c, shadow_shift_c, rd_load_c, rd_shift_c;
  logic                    do_commit_c, set_err_c, clr_err_c;
  logic [N_LUTS*OUT_WIDTH-1:0] lookup_c;

  assign hdr_next_c = {hdr[HDR_BITS-2:0], d};
  assign idx_next_c = hdr_next_c[IDX_W-1:0];
  assign idx_ok_c   = {1'b0, idx} < IDXE_W'(N_LUTS);
  assign cnt_full_c = (cnt == CNT_W'(TABLE_BITS));

  assign q    = (state == S_READ) ? rd[TABLE_BITS-1] : 1'b0;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Frame sequencing: header decode, data phase, frame-end resolution
  always_comb begin
    state_next     = state;
    hdr_en_c       = 1'b0;
    idx_load_c     = 1'b0;
    shadow_shift_c = 1'b0;
    rd_load_c      = 1'b0;
    rd_shift_c     = 1'b0;
    do_commit_c    = 1'b0;
    set_err_c      = 1'b0;
    clr_err_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!cs_n) begin
          state_next = S_HEADER;
          hdr_en_c   = 1'b1;
          clr_err_c  = 1'b1;
        end
      end
      S_HEADER: begin
        if (cs_n) begin
          state_next = S_IDLE;
          set_err_c  = 1'b1;
        end else begin
          hdr_en_c = 1'b1;
          if (hcnt == HCNT_W'(HDR_BITS - 1)) begin
            idx_load_c = 1'b1;
            if (hdr_next_c[HDR_BITS-1]) begin
              state_next = S_WRITE;
            end else begin
              state_next = S_READ;
              rd_load_c  = 1'b1;
            end
          end
        end
      end
      S_WRITE: begin
        if (cs_n) begin
          state_next = S_IDLE;
          if (cnt_full_c && idx_ok_c) do_commit_c = 1'b1;
          else                        set_err_c   = 1'b1;
        end else if (cnt_full_c) begin
          state_next = S_HOLD;
          set_err_c  = 1'b1;
        end else begin
          shadow_shift_c = 1'b1;
        end
      end
      S_READ: begin
        if (cs_n) begin
          state_next = S_IDLE;
          if (!idx_ok_c) set_err_c = 1'b1;
        end else begin
          rd_shift_c = 1'b1;
        end
      end
      S_HOLD: begin
        if (cs_n) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Per-channel table lookup with constant slice bounds
  always_comb begin
    lookup_c = '0;
    for (int unsigned k = 0; k < N_LUTS; k++) begin
      for (int unsigned e = 0; e < N_ENTRIES; e++) begin
        if (sel[k*IN_WIDTH +: IN_WIDTH] == IN_WIDTH'(e))
          lookup_c[k*OUT_WIDTH +: OUT_WIDTH] = active[k][e*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr    <= '0;
      hcnt   <= '0;
      idx    <= '0;
      cnt    <= '0;
      shadow <= '0;
      rd     <= '0;
      commit <= 1'b0;
      err    <= 1'b0;
      out    <= '0;
      for (int unsigned k = 0; k < N_LUTS; k++) active[k] <= '0;
    end else begin
      out    <= lookup_c;
      commit <= do_commit_c;
      if (hdr_en_c) begin
        hdr  <= hdr_next_c;
        hcnt <= (state == S_IDLE) ? HCNT_W'(1) : hcnt + HCNT_W'(1);
        cnt  <= '0;
      end
      if (idx_load_c) idx <= idx_next_c;
      if (shadow_shift_c) begin
        shadow <= {shadow[TABLE_BITS-2:0], d};
        cnt    <= cnt + CNT_W'(1);
      end
      // Out-of-range channel reads back as all zeros
      if (rd_load_c) begin
        rd <= '0;
        for (int unsigned k = 0; k < N_LUTS; k++)
          if (idx_next_c == IDX_W'(k)) rd <= active[k];
      end else if (rd_shift_c) begin
        rd <= {rd[TABLE_BITS-2:0], 1'b0};
      end
      if (clr_err_c)      err <= 1'b0;
      else if (set_err_c) err <= 1'b1;
      if (do_commit_c) begin
        for (int unsigned k = 0; k < N_LUTS; k++)
          if (idx == IDX_W'(k)) active[k] <= shadow;
      end
    end
  end

endmodule

// File: tb/tb_serial_cfg_lut_bank.sv
// Randomized bench for serial_cfg_lut_bank against a table-of-entries reference model.
module tb_serial_cfg_lut_bank;

  localparam int IW = 4;
  localparam int OW = 4;
  localparam int NL = 2;
  localparam int NE = 16;
  localparam int TBITS = NE * OW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cs_n, d;
  logic [NL*IW-1:0] sel;
  logic [NL*OW-1:0] out;
  logic            q, busy, commit, err;

  logic            cs3_n, d3;
  logic [3*IW-1:0] sel3;
  logic [3*OW-1:0] out3;
  logic            q3, busy3, commit3, err3;

  int vectors = 0;
  int miscompares = 0;
  int model [NL][NE];

  serial_cfg_lut_bank dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .d(d), .sel(sel), .out(out),
    .q(q), .busy(busy), .commit(commit), .err(err)
  );

  serial_cfg_lut_bank #(.IN_WIDTH(4), .OUT_WIDTH(4), .N_LUTS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs3_n), .d(d3), .sel(sel3), .out(out3),
    .q(q3), .busy(busy3), .commit(commit3), .err(err3)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Serial stream position j carries table bit (TBITS-1-j)
  function automatic logic stream_bit(input int ent[NE], input int j);
    int b;
    b = TBITS - 1 - j;
    return 1'((ent[b / OW] >> (b % OW)) & 1);
  endfunction

  // One clock; every cycle the registered lookup is compared with the model
  task automatic tick();
    logic [NL*OW-1:0] exp;
    int s;
    exp = '0;
    for (int k = 0; k < NL; k++) begin
      s = int'(sel[k*IW +: IW]);
      exp[k*OW +: OW] = 4'(model[k][s]);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out !== exp) begin
      miscompares++;
      $display("FAIL lookup_out: got %h want %h", out, exp);
    end
    sel  = NL*IW'($urandom);
    sel3 = 3*IW'($urandom);
  endtask

  task automatic send_bit(input logic b);
    cs_n = 1'b0;
    d    = b;
    tick();
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    d    = 1'b0;
    tick();
  endtask

  task automatic write_table(input int ch, input int ent[NE], input int nbits);
    send_bit(1'b1);
    send_bit(1'(ch));
    for (int j = 0; j < nbits; j++)
      send_bit((j < TBITS) ? stream_bit(ent, j) : 1'($urandom));
  endtask

  task automatic test_reset();
    logic [3:0] s;
    rst_n = 1'b0; cs_n = 1'b1; d = 1'b0; cs3_n = 1'b1; d3 = 1'b0; sel3 = '0;
    for (int c = 0; c < NL; c++) for (int e = 0; e < NE; e++) model[c][e] = 0;
    for (int v = 0; v < NE; v++) begin
      s = 4'(v);
      sel = {s, s};
      #7;
      vectors++;
      if (out !== '0 || q !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || commit !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state: got out=%h q=%b busy=%b err=%b commit=%b want all zero",
                 out, q, busy, err, commit);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_readback(input int ch);
    int ent [NE];
    logic expb;
    for (int e = 0; e < NE; e++) ent[e] = model[ch][e];
    send_bit(1'b0);
    send_bit(1'(ch));
    for (int j = 0; j < TBITS + 2; j++) begin
      expb = (j < TBITS) ? stream_bit(ent, j) : 1'b0;
      vectors++;
      if (q !== expb) begin
        miscompares++;
        $display("FAIL readback_q ch%0d bit%0d: got %b want %b", ch, j, q, expb);
      end
      send_bit(1'($urandom));
    end
    end_frame();
    vectors++;
    if (err !== 1'b0 || commit !== 1'b0 || q !== 1'b0) begin
      miscompares++;
      $display("FAIL readback_end: got err=%b commit=%b q=%b want 0 0 0", err, commit, q);
    end
  endtask

  task automatic test_write_ch1();
    int ent [NE];
    for (int i = 0; i < NE; i++) ent[i] = 15 - i;
    write_table(1, ent, TBITS);
    vectors++;
    if (commit !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL write_pre_end: got commit=%b busy=%b want 0 1", commit, busy);
    end
    end_frame();
    for (int i = 0; i < NE; i++) model[1][i] = ent[i];
    vectors++;
    if (commit !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL write_commit: got commit=%b err=%b busy=%b want 1 0 0", commit, err, busy);
    end
    sel = 8'h33;
    tick();
    vectors++;
    if (commit !== 1'b0) begin
      miscompares++;
      $display("FAIL commit_width: got %b want 0", commit);
    end
    sel = 8'h33;
    tick();
    vectors++;
    if (out !== 8'hc0) begin
      miscompares++;
      $display("FAIL ch1_sel3: got %h want c0", out);
    end
  endtask

  task automatic test_short_frame();
    int ent [NE];
    for (int e = 0; e < NE; e++) ent[e] = int'($urandom_range(0, 15));
    write_table(0, ent, TBITS - 1);
    end_frame();
    vectors++;
    if (commit !== 1'b0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL short_frame: got commit=%b err=%b want 0 1", commit, err);
    end
    tick();
    send_bit(1'b0);
    vectors++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL err_clear: got err=%b busy=%b want 0 1", err, busy);
    end
    send_bit(1'b0);
    end_frame();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL short_read_end: got err=%b want 0", err);
    end
  endtask

  task automatic test_overrun();
    int ent [NE];
    for (int e = 0; e < NE; e++) ent[e] = int'($urandom_range(0, 15));
    write_table(0, ent, TBITS + 1);
    vectors++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_hold: got err=%b busy=%b want 1 1", err, busy);
    end
    for (int j = 0; j < 4; j++) send_bit(1'($urandom));
    end_frame();
    vectors++;
    if (commit !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_end: got commit=%b err=%b busy=%b want 0 1 0", commit, err, busy);
    end
    tick();
  endtask

  task automatic test_header_abort();
    send_bit(1'b1);
    end_frame();
    vectors++;
    if (commit !== 1'b0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL header_abort: got commit=%b err=%b want 0 1", commit, err);
    end
    tick();
  endtask

  task automatic test_bad_idx();
    logic [2:0] hw;
    logic [2:0] hr;
    hw = 3'b111;
    hr = 3'b011;
    for (int j = 0; j < 3; j++) begin cs3_n = 1'b0; d3 = hw[2-j]; tick(); end
    for (int j = 0; j < TBITS; j++) begin cs3_n = 1'b0; d3 = 1'($urandom); tick(); end
    cs3_n = 1'b1; d3 = 1'b0; tick();
    vectors++;
    if (commit3 !== 1'b0 || err3 !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_idx_write: got commit=%b err=%b want 0 1", commit3, err3);
    end
    tick();
    vectors++;
    if (out3 !== '0) begin
      miscompares++;
      $display("FAIL bad_idx_tables: got %h want 0", out3);
    end
    for (int j = 0; j < 3; j++) begin cs3_n = 1'b0; d3 = hr[2-j]; tick(); end
    for (int j = 0; j < 8; j++) begin
      vectors++;
      if (q3 !== 1'b0) begin
        miscompares++;
        $display("FAIL bad_idx_read bit%0d: got %b want 0", j, q3);
      end
      cs3_n = 1'b0; d3 = 1'b1; tick();
    end
    cs3_n = 1'b1; tick();
    vectors++;
    if (err3 !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_idx_read_end: got err=%b want 1", err3);
    end
  endtask

  task automatic test_random_frames();
    int ent [NE];
    int ch;
    for (int it = 0; it < 6; it++) begin
      ch = int'($urandom_range(0, NL - 1));
      for (int e = 0; e < NE; e++) ent[e] = int'($urandom_range(0, 15));
      write_table(ch, ent, TBITS);
      end_frame();
      for (int e = 0; e < NE; e++) model[ch][e] = ent[e];
      vectors++;
      if (commit !== 1'b1 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_commit it%0d: got commit=%b err=%b want 1 0", it, commit, err);
      end
      for (int t = 0; t < 3; t++) tick();
      test_readback(ch);
    end
  endtask

  task automatic test_reset_midframe();
    int ent [NE];
    for (int e = 0; e < NE; e++) ent[e] = int'($urandom_range(0, 15));
    write_table(0, ent, 30);
    cs_n = 1'b0; d = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < NL; c++) for (int e = 0; e < NE; e++) model[c][e] = 0;
    vectors++;
    if (out !== '0 || busy !== 1'b0 || commit !== 1'b0 || err !== 1'b0 || q !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_reset: got out=%h busy=%b commit=%b err=%b q=%b want all zero",
               out, busy, commit, err, q);
    end
    cs_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    tick();
    vectors++;
    if (commit !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got commit=%b busy=%b want 0 0", commit, busy);
    end
    write_table(0, ent, TBITS);
    end_frame();
    for (int e = 0; e < NE; e++) model[0][e] = ent[e];
    vectors++;
    if (commit !== 1'b1 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_commit: got commit=%b err=%b want 1 0", commit, err);
    end
    tick();
    test_readback(0);
  endtask

  initial begin
    test_reset();
    test_write_ch1();
    test_readback(1);
    test_short_frame();
    test_overrun();
    test_header_abort();
    test_bad_idx();
    test_random_frames();
    test_reset_midframe();
    for (int t = 0; t < 4; t++) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
